byte_framer: RTL and testbench

Upstream framing stage for the valid/last-gated output register bank. Accepts bytes from a producer over a valid/ready handshake, buffers them in a small FIFO, and emits a push-only stream with `out_valid` and `out_last` that directly drives the downstream `valid`/`last`/`in` inputs. Frames are a fixed number of bytes unless cut short by `flush`.

---
 rtl/byte_framer.sv | 148 ++++++++++++++
 tb/tb_byte_framer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_framer.sv
// Byte framer: valid/ready byte intake, small FIFO, registered push-only frame stream.
// Optional inter-frame idle gap enabled by defining BYTE_FRAMER_GAP_EN.
module byte_framer #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int FRAME_LEN  = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          flush,
   output logic                          out_valid,
   output logic                          out_last,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                flush_pend_q, flush_pend_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                push, pop, pop_last;

`ifdef BYTE_FRAMER_GAP_EN
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
`endif

   // Full-FIFO ready stays low even when a pop happens in the same cycle.
   assign in_ready   = (level_q != LW'(FIFO_DEPTH));
   assign push       = in_valid && in_ready;
   assign pop        = (state_q == SEND) && (level_q != '0);
   assign pop_last   = pop && ((idx_q == IW'(FRAME_LEN - 1)) || flush_pend_q || flush);

   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign out_data   = out_data_q;
   assign fifo_level = level_q;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d      = level_q;
      idx_d        = idx_q;
      flush_pend_d = flush_pend_q | flush;
      out_valid_d  = pop;
      out_last_d   = pop_last;
      out_data_d   = pop ? mem[rd_ptr_q] : out_data_q;
`ifdef BYTE_FRAMER_GAP_EN
      gap_cnt_d    = gap_cnt_q;
`endif

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (pop) begin
         idx_d = pop_last ? '0 : idx_q + IW'(1);
      end
      if (pop_last) begin
         flush_pend_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (level_q != '0) state_d = SEND;
         end
         SEND: begin
            if (pop_last) begin
`ifdef BYTE_FRAMER_GAP_EN
               state_d   = GAP;
               gap_cnt_d = '0;
`else
               state_d   = SEND;
`endif
            end else if (level_q == '0 || level_d == '0) begin
               state_d = IDLE;
            end
         end
`ifdef BYTE_FRAMER_GAP_EN
         GAP: begin
            if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
               state_d = (level_q != '0) ? SEND : IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         idx_q        <= '0;
         flush_pend_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
`ifdef BYTE_FRAMER_GAP_EN
         gap_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         idx_q        <= idx_d;
         flush_pend_q <= flush_pend_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
`ifdef BYTE_FRAMER_GAP_EN
         gap_cnt_q    <= gap_cnt_d;
`endif
      end
   end

   // NOTE: storage is deliberately not reset; the level and pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_byte_framer.sv
// Self-checking bench for byte_framer: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_byte_framer;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int FL    = 4;
   localparam int GC    = 2;
`ifdef BYTE_FRAMER_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, in_valid, flush;
   logic [DW-1:0] in_data;
   logic          in_ready, out_valid, out_last;
   logic [DW-1:0] out_data;
   logic [$clog2(DEPTH):0] fifo_level;

   byte_framer #(
      .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .GAP_CYCLES(GC)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .flush(flush), .out_valid(out_valid),
      .out_last(out_last), .out_data(out_data), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: byte queue, frame position, pending-flush flag, gap window.
   logic [DW-1:0] m_q[$];
   bit            m_prev_ne;
   int            m_gap, m_pos;
   bit            m_fpend;
   bit            e_v, e_l;
   logic [DW-1:0] e_d;

   logic [DW-1:0] cap_d[$];
   bit            cap_l[$];
   int            cap_t[$];
   bit            saw_full;

   task automatic model_edge();
      bit ne, blocked, pop, last;
      if (rst) begin
         m_q.delete();
         m_prev_ne = 0; m_gap = 0; m_pos = 0; m_fpend = 0;
         e_v = 0; e_l = 0; e_d = '0;
         return;
      end
      ne      = (m_q.size() != 0);
      blocked = (m_gap > 0);
      if (blocked) m_gap--;
      // A byte can only leave once the FIFO was already occupied the cycle before.
      pop = ne && m_prev_ne && !blocked;
      e_v = 0; e_l = 0;
      if (pop) begin
         last = (m_pos == FL - 1) || m_fpend || flush;
         e_v  = 1; e_l = last;
         e_d  = m_q.pop_front();
         if (last) begin
            m_pos = 0; m_fpend = 0;
            if (GAP_ON) m_gap = GC;
         end else begin
            m_pos++;
         end
      end else if (flush) begin
         m_fpend = 1;
      end
      if (in_valid && (m_q.size() + (pop ? 1 : 0) != DEPTH)) m_q.push_back(in_data);
      m_prev_ne = ne;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("out_valid",  out_valid,  e_v);
      check("out_last",   out_last,   e_l);
      check("out_data",   out_data,   e_d);
      check("fifo_level", fifo_level, m_q.size());
      check("in_ready",   in_ready,   m_q.size() != DEPTH);
      if (out_valid) begin
         cap_d.push_back(out_data); cap_l.push_back(out_last); cap_t.push_back(cyc);
      end
      if (fifo_level == DEPTH && !in_ready) saw_full = 1;
      cyc++;
   endtask

   task automatic idle(int n);
      in_valid = 0; flush = 0;
      repeat (n) step();
   endtask

   task automatic push_byte(logic [DW-1:0] b);
      bit rdy = 0;
      in_valid = 1; in_data = b;
      for (int n = 0; n < 40 && !rdy; n++) begin
         rdy = in_ready;
         step();
      end
      check("push_accept", rdy, 1);
      in_valid = 0;
   endtask

   task automatic clear_cap();
      cap_d.delete(); cap_l.delete(); cap_t.delete();
   endtask

   task automatic check_cap(string tag, logic [DW-1:0] ed[$], bit el[$]);
      check({tag, "_count"}, cap_d.size(), ed.size());
      if (cap_d.size() == ed.size()) begin
         foreach (ed[i]) begin
            check({tag, "_data"}, cap_d[i], ed[i]);
            check({tag, "_last"}, cap_l[i], el[i]);
         end
      end
   endtask

   logic [DW-1:0] exp_d[$];
   bit            exp_l[$];
   int            c0;

   initial begin
      rst = 1; in_valid = 0; flush = 0; in_data = '0; saw_full = 0;
      step(); step();
      rst = 0;
      check("rst_out_valid",  out_valid,  0);
      check("rst_out_last",   out_last,   0);
      check("rst_out_data",   out_data,   0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_in_ready",   in_ready,   1);

      // Single frame: bytes appear two edges after acceptance, last only on 0x44.
      idle(3); clear_cap();
      c0 = cyc;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      idle(6);
      exp_d = {8'h11, 8'h22, 8'h33, 8'h44};
      exp_l = {1'b0, 1'b0, 1'b0, 1'b1};
      check_cap("single", exp_d, exp_l);
      if (cap_t.size() == 4)
         foreach (cap_t[i]) check("single_timing", cap_t[i], c0 + 2 + i);

      // Early flush coincident with the pop of 0xA1; 0xB0 then starts a fresh frame.
      idle(3); clear_cap();
      push_byte(8'hA0); push_byte(8'hA1);
      step();
      flush = 1; step(); flush = 0;
      idle(3);
      push_byte(8'hB0); push_byte(8'hB1); push_byte(8'hB2); push_byte(8'hB3);
      idle(6);
      exp_d = {8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
      exp_l = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      check_cap("early_flush", exp_d, exp_l);

      // Flush while empty is held and turns the next byte into a 1-byte frame.
      idle(3); clear_cap();
      flush = 1; step(); flush = 0;
      idle(2);
      push_byte(8'hC5);
      idle(4);
      push_byte(8'hD0); push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3);
      idle(6);
      exp_d = {8'hC5, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
      exp_l = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      check_cap("empty_flush", exp_d, exp_l);

      // Eight queued bytes: contiguous output, or a GC-cycle hole after byte 3 with the gap.
      idle(3); clear_cap();
      for (int i = 0; i < 8; i++) push_byte(DW'(8'h60 + i));
      idle(12);
      check("gap_count", cap_t.size(), 8);
      if (cap_t.size() == 8) begin
         for (int i = 1; i < 8; i++)
            check("gap_spacing", cap_t[i] - cap_t[i-1], (GAP_ON && i == 4) ? GC + 1 : 1);
         check("gap_last3", cap_l[3], 1);
         check("gap_last7", cap_l[7], 1);
      end

`ifdef BYTE_FRAMER_GAP_EN
      // Pushing through the gap window fills the FIFO and drops in_ready.
      idle(4); saw_full = 0;
      for (int i = 0; i < 12; i++) push_byte(DW'(8'h80 + i));
      idle(16);
      check("full_seen", saw_full, 1);
`endif

      // Reset mid-frame: two bytes out, two still queued, then a one-cycle reset.
      idle(4); clear_cap();
      push_byte(8'hF0); push_byte(8'hF1); push_byte(8'hF2); push_byte(8'hF3);
      check("midrst_emitted", cap_d.size(), 2);
      check("midrst_level",   fifo_level, 2);
      rst = 1; step(); rst = 0;
      check("midrst_out_valid",  out_valid,  0);
      check("midrst_out_last",   out_last,   0);
      check("midrst_out_data",   out_data,   0);
      check("midrst_fifo_level", fifo_level, 0);
      check("midrst_in_ready",   in_ready,   1);
      clear_cap();
      push_byte(8'hE0); push_byte(8'hE1); push_byte(8'hE2); push_byte(8'hE3);
      idle(6);
      exp_d = {8'hE0, 8'hE1, 8'hE2, 8'hE3};
      exp_l = {1'b0, 1'b0, 1'b0, 1'b1};
      check_cap("post_rst", exp_d, exp_l);

      // Random traffic with occasional flushes and resets.
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = DW'($urandom);
         flush    = ($urandom_range(0, 15) == 0);
         step();
      end
      rst = 0;
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
